rvee_clint: RTL

Core-local interruptor for rvee: an AXI4-Lite responder that sits on the core's data-memory bus and owns the machine timer and software-interrupt registers. It holds a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and a 1-bit `msip` register. It drives the core's `mtip` and `msip` inputs from them.

---
 rtl/rvee_clint_if.sv | 33 +++
 rtl/rvee_clint.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rvee_clint_if.sv
// AXI4-Lite bus bundle shared by the rvee data-memory bus and its responders.
interface axi4lite_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) ();
    logic [AWIDTH-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DWIDTH-1:0]   wdata;
    logic [DWIDTH/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [AWIDTH-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DWIDTH-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave_port (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master_port (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/rvee_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind an AXI4-Lite responder.
// Optional mtime prescaler enabled by defining RVEE_CLINT_PRESCALE_EN.
module rvee_clint #(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int PRESCALE = 1
) (
    input  logic           clk,
    input  logic           rst,
    axi4lite_if.slave_port axi_if,
    output logic           mtip,
    output logic           msip
);

    localparam logic [13:0] IDX_MSIP    = 14'h0000;
    localparam logic [13:0] IDX_CMP_LO  = 14'h1000;
    localparam logic [13:0] IDX_CMP_HI  = 14'h1001;
    localparam logic [13:0] IDX_TIME_LO = 14'h2FFE;
    localparam logic [13:0] IDX_TIME_HI = 14'h2FFF;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic                alive;
    logic                aw_held, w_held;
    logic [13:0]         aw_idx_q;
    logic [DWIDTH-1:0]   w_data_q;
    logic [DWIDTH/8-1:0] w_strb_q;
    logic                bvalid_q, rvalid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [DWIDTH-1:0]   rdata_q;
    logic [63:0]         mtime, mtimecmp;
    logic                msip_q, mtip_q, tick;

    logic                awready, wready, arready;
    logic                aw_fire, w_fire, ar_fire, b_fire, r_fire, do_write;
    logic [13:0]         wr_idx, rd_idx;
    logic [DWIDTH-1:0]   wr_data, rd_data;
    logic [DWIDTH/8-1:0] wr_strb;
    logic [1:0]          rd_resp;
    logic                wr_mapped;
    logic                we_msip, we_cmp_lo, we_cmp_hi, we_time_lo, we_time_hi;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int unsigned i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    // alive keeps every ready low while in reset and for the first edge after it
    assign awready  = alive & ~aw_held & ~bvalid_q;
    assign wready   = alive & ~w_held & ~bvalid_q;
    assign arready  = alive & ~rvalid_q;
    assign aw_fire  = axi_if.awvalid & awready;
    assign w_fire   = axi_if.wvalid & wready;
    assign ar_fire  = axi_if.arvalid & arready;
    assign b_fire   = bvalid_q & axi_if.bready;
    assign r_fire   = rvalid_q & axi_if.rready;
    assign do_write = (aw_held | aw_fire) & (w_held | w_fire) & ~bvalid_q;

    assign wr_idx  = aw_held ? aw_idx_q : axi_if.awaddr[15:2];
    assign wr_data = w_held ? w_data_q : axi_if.wdata;
    assign wr_strb = w_held ? w_strb_q : axi_if.wstrb;
    assign rd_idx  = axi_if.araddr[15:2];

    always_comb begin
        we_msip    = 1'b0;
        we_cmp_lo  = 1'b0;
        we_cmp_hi  = 1'b0;
        we_time_lo = 1'b0;
        we_time_hi = 1'b0;
        wr_mapped  = 1'b1;
        case (wr_idx)
            IDX_MSIP:    we_msip    = do_write;
            IDX_CMP_LO:  we_cmp_lo  = do_write;
            IDX_CMP_HI:  we_cmp_hi  = do_write;
            IDX_TIME_LO: we_time_lo = do_write;
            IDX_TIME_HI: we_time_hi = do_write;
            default:     wr_mapped  = 1'b0;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_idx)
            IDX_MSIP:    rd_data[0] = msip_q;
            IDX_CMP_LO:  rd_data = mtimecmp[31:0];
            IDX_CMP_HI:  rd_data = mtimecmp[63:32];
            IDX_TIME_LO: rd_data = mtime[31:0];
            IDX_TIME_HI: rd_data = mtime[63:32];
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive    <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            alive <= 1'b1;
            if (b_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= axi_if.awaddr[15:2];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= axi_if.wdata;
                    w_strb_q <= axi_if.wstrb;
                end
            end
            if (do_write) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (b_fire) begin
                bvalid_q <= 1'b0;
            end
            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (r_fire) begin
                rvalid_q <= 1'b0;
            end
        end
    end

`ifdef RVEE_CLINT_PRESCALE_EN
    localparam logic [15:0] RELOAD = 16'(PRESCALE - 1);
    logic [15:0] pre_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        pre_cnt <= RELOAD;
        else if (we_time_lo | we_time_hi | tick)         pre_cnt <= RELOAD;
        else                                             pre_cnt <= pre_cnt - 16'd1;
    end

    assign tick = (pre_cnt == '0);
`else
    logic unused_prescale;
    assign unused_prescale = ^32'(PRESCALE);
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime    <= '0;
            mtimecmp <= '1;
            msip_q   <= 1'b0;
            mtip_q   <= 1'b0;
        end else begin
            mtip_q <= (mtime >= mtimecmp);
            if (we_msip && wr_strb[0]) msip_q <= wr_data[0];
            if (we_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0], wr_data, wr_strb);
            if (we_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], wr_data, wr_strb);
            // a write to either half replaces this cycle's tick
            if (we_time_lo || we_time_hi) begin
                if (we_time_lo) mtime[31:0]  <= merge(mtime[31:0], wr_data, wr_strb);
                if (we_time_hi) mtime[63:32] <= merge(mtime[63:32], wr_data, wr_strb);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    logic unused_addr;
    assign unused_addr = ^{axi_if.awaddr[AWIDTH-1:16], axi_if.awaddr[1:0],
                           axi_if.araddr[AWIDTH-1:16], axi_if.araddr[1:0]};

    assign axi_if.awready = awready;
    assign axi_if.wready  = wready;
    assign axi_if.arready = arready;
    assign axi_if.bvalid  = bvalid_q;
    assign axi_if.bresp   = bresp_q;
    assign axi_if.rvalid  = rvalid_q;
    assign axi_if.rresp   = rresp_q;
    assign axi_if.rdata   = rdata_q;
    assign mtip           = mtip_q;
    assign msip           = msip_q;

endmodule
